// File: rtl/hazard_forward_unit_pkg.sv
// hazard_forward_unit_pkg: shared forward encodings, FSM states and address width
package hazard_forward_unit_pkg;
  localparam int REG_ADDR_W = 4;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;
endpackage

// File: rtl/hazard_forward_unit_forward_select.sv
// forward_select: per-operand forward source comparator, youngest producer wins
module forward_select #(
  parameter int REG_ADDR_W = hazard_forward_unit_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  regwrite_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  regwrite_mem,
  output logic [1:0]            fwd
);
  import hazard_forward_unit_pkg::*;
  logic hit_ex, hit_mem;
  assign hit_ex  = regwrite_ex && rd_ex != '0 && rd_ex == rs;
  assign hit_mem = regwrite_mem && rd_mem != '0 && rd_mem == rs;
  assign fwd = hit_ex ? FWD_ALU : hit_mem ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: registered forward selects plus load-use stall and branch flush control
module hazard_forward_unit #(
  parameter int REG_ADDR_W        = hazard_forward_unit_pkg::REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  regwrite_ex,
  input  logic                  memread_ex,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  regwrite_mem,
  input  logic                  branch_taken_ex,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_idex,
  output logic                  flush_ifid,
  output logic [15:0]           stall_count
);
  import hazard_forward_unit_pkg::*;
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  logic [15:0] stall_count_q, stall_count_d;
  logic        load_use, stall, flush;
  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(rs1_id), .rd_ex, .regwrite_ex, .rd_mem, .regwrite_mem, .fwd(sel_a)
  );
  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(rs2_id), .rd_ex, .regwrite_ex, .rd_mem, .regwrite_mem, .fwd(sel_b)
  );
  assign load_use = memread_ex && rd_ex != '0 && (rd_ex == rs1_id || rd_ex == rs2_id);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    if (branch_taken_ex) begin
      flush   = 1'b1;
      state_d = FLUSH;
      cnt_d   = '0;
    end else if (state_q == FLUSH) begin
      flush   = 1'b1;
      state_d = RUN;
    end else if (state_q == STALL) begin
      stall   = 1'b1;
      cnt_d   = cnt_q - 3'd1;
      state_d = cnt_q <= 3'd1 ? RUN : STALL;
    end else if (load_use) begin
      stall   = 1'b1;
      cnt_d   = 3'(LOAD_STALL_CYCLES - 1);
      state_d = LOAD_STALL_CYCLES > 1 ? STALL : RUN;
    end
  end
  // Gated by reset_n so nothing stalls or flushes while reset is held
  assign stall_pc    = stall & reset_n;
  assign stall_ifid  = stall & reset_n;
  assign flush_ifid  = flush & reset_n;
  assign bubble_idex = (stall | flush) & reset_n;
  always_comb begin
    fwd_a_d       = bubble_idex ? FWD_REG : stall_ifid ? fwd_a_q : sel_a;
    fwd_b_d       = bubble_idex ? FWD_REG : stall_ifid ? fwd_b_q : sel_b;
    stall_count_d = (stall_pc && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      fwd_a_q       <= FWD_REG;
      fwd_b_q       <= FWD_REG;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign forwardA    = fwd_a_q;
  assign forwardB    = fwd_b_q;
  assign stall_count = stall_count_q;
endmodule
